// File: rtl/sram_async_ctrl_pkg.sv
// sram_async_ctrl_pkg: shared state encoding, default widths and SRAM timing constants (ns)
package sram_async_ctrl_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam real T_AA = 8.0;
  localparam real T_WP = 5.0;
  localparam real T_DW = 3.5;
  localparam real T_OHZ = 3.5;
  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    R_TURN
  } state_t;
endpackage

// File: rtl/sram_async_ctrl_cnt.sv
// sram_async_ctrl_cnt: loadable down-counter that parks at zero and flags it
module sram_async_ctrl_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) cnt <= rst ? '0 : load ? load_val : zero ? cnt : cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: request bus to async SRAM strobe sequencer; define SRAM_ASYNC_CTRL_B2B_RD_EN for back-to-back reads
module sram_async_ctrl
  import sram_async_ctrl_pkg::*;
#(
  parameter int  ADDR_W       = ADDR_W_DEF,
  parameter int  DATA_W       = DATA_W_DEF,
  parameter int  RD_WAIT_CYC  = 1,
  parameter int  WR_PULSE_CYC = 1,
  parameter real T_CLK_NS     = 10.0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs_b,
  output logic              sram_oe_b,
  output logic              sram_we_b,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);
  localparam int CW = $clog2(RD_WAIT_CYC > WR_PULSE_CYC ? RD_WAIT_CYC : WR_PULSE_CYC) + 1;
  if (RD_WAIT_CYC < 1 || RD_WAIT_CYC * T_CLK_NS < T_AA) begin : g_bad_rd
    $error("RD_WAIT_CYC too small for t_AA");
  end
  if (WR_PULSE_CYC < 1 || WR_PULSE_CYC * T_CLK_NS < T_WP || T_CLK_NS < T_DW) begin : g_bad_wr
    $error("WR_PULSE_CYC too small for t_WP/t_DW");
  end
  if (T_CLK_NS < T_OHZ) begin : g_bad_turn
    $error("clock too fast for a one-cycle bus turnaround");
  end
  state_t state, nxt;
  logic ready_q, b2b_acc, accept, cnt_zero, load, rd_done;
  logic [CW-1:0] load_val;
`ifdef SRAM_ASYNC_CTRL_B2B_RD_EN
  assign b2b_acc = state == R_ACCESS && cnt_zero && req_valid && !req_wr;
`else
  assign b2b_acc = 1'b0;
`endif
  assign req_ready = ready_q | b2b_acc;
  assign accept = req_valid & req_ready;
  assign rd_done = state == R_ACCESS && cnt_zero;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !accept ? IDLE : req_wr ? W_SETUP : R_ACCESS;
      W_SETUP:  nxt = W_PULSE;
      W_PULSE:  nxt = cnt_zero ? W_HOLD : W_PULSE;
      W_HOLD:   nxt = IDLE;
      R_ACCESS: nxt = !cnt_zero || b2b_acc ? R_ACCESS : R_TURN;
      R_TURN:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // a back-to-back read re-enters R_ACCESS from its own last cycle and must reload
    load = (nxt == W_PULSE && state != W_PULSE) || (nxt == R_ACCESS && (state != R_ACCESS || cnt_zero));
    load_val = nxt == R_ACCESS ? CW'(RD_WAIT_CYC - 1) : CW'(WR_PULSE_CYC - 1);
  end
  sram_async_ctrl_cnt #(.W(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .zero(cnt_zero)
  );
  // strobes are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready_q <= 1'b0;
      sram_cs_b <= 1'b1;
      sram_oe_b <= 1'b1;
      sram_we_b <= 1'b1;
      sram_dout_en <= 1'b0;
      sram_addr <= '0;
      sram_dout <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      ready_q <= nxt == IDLE;
      sram_cs_b <= !(nxt inside {W_SETUP, W_PULSE, W_HOLD, R_ACCESS});
      sram_oe_b <= nxt != R_ACCESS;
      sram_we_b <= nxt != W_PULSE;
      sram_dout_en <= nxt inside {W_SETUP, W_PULSE, W_HOLD};
      rsp_valid <= rd_done;
      if (accept) sram_addr <= req_addr;
      if (accept && req_wr) sram_dout <= req_wdata;
      if (rd_done) rsp_rdata <= sram_din;
    end
  end
endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb_sram_async_ctrl: directed scoreboard bench for sram_async_ctrl with an SRAM model
module tb_sram_async_ctrl;
`ifdef SRAM_ASYNC_CTRL_B2B_RD_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid, req_wr, req_ready, rsp_valid;
  logic [10:0] req_addr, sram_addr;
  logic [7:0] req_wdata, rsp_rdata, sram_dout, sram_din;
  logic sram_cs_b, sram_oe_b, sram_we_b, sram_dout_en;
  logic v2, wr2, rdy2, rsp2, cs2, oe2, we2, den2;
  logic [10:0] a2, sa2;
  logic [7:0] d2, rd2, so2, si2;
  logic [7:0] mem [2048];
  logic [7:0] mem2 [2048];
  logic [7:0] exp_mem [2048];
  logic [7:0] exp_q[$];
  logic [7:0] q2[$];
  int rsp_t[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, hs = 0, we_low = 0, rdy2_low = 0, we2_low = 0, oe2_low = 0, rsp2_n = 0;
  int r0, w0, o0, n;

  sram_async_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_cs_b(sram_cs_b), .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );
  sram_async_ctrl #(.RD_WAIT_CYC(2), .WR_PULSE_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_wr(wr2),
    .req_addr(a2), .req_wdata(d2), .rsp_valid(rsp2), .rsp_rdata(rd2),
    .sram_addr(sa2), .sram_cs_b(cs2), .sram_oe_b(oe2), .sram_we_b(we2),
    .sram_dout(so2), .sram_dout_en(den2), .sram_din(si2)
  );

  always @(posedge clk) begin
    if (!sram_cs_b && !sram_we_b && sram_dout_en) mem[sram_addr] = sram_dout;
    if (!cs2 && !we2 && den2) mem2[sa2] = so2;
  end
  assign sram_din = (!sram_cs_b && !sram_oe_b) ? mem[sram_addr] : 8'h00;
  assign si2 = (!cs2 && !oe2) ? mem2[sa2] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("inv_dout_en_oe", {31'b0, sram_dout_en & ~sram_oe_b}, 0);
      check("inv_we_cs", {31'b0, ~sram_we_b & sram_cs_b}, 0);
      if (req_valid && req_ready) hs++;
      if (!sram_we_b) we_low++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rdata", {24'b0, rsp_rdata}, {24'b0, exp_q.pop_front()});
        rsp_t.push_back(cyc);
      end
      if (!rdy2) rdy2_low++;
      if (!we2) we2_low++;
      if (!oe2) oe2_low++;
      if (rsp2) begin
        rsp2_n++;
        if (q2.size() == 0) check("rsp2_unexpected", 1, 0);
        else check("rdata2", {24'b0, rd2}, {24'b0, q2.pop_front()});
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready();
    int m = 0;
    #1;
    while (!req_ready && m < 20) begin tick(); m++; end
    if (m == 20) check("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic wr, input logic [10:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    if (wr) exp_mem[a] = d;
    else exp_q.push_back(exp_mem[a]);
    wait_ready();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    v2 = 0; wr2 = 0; a2 = 0; d2 = 0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i * 7); exp_mem[i] = 8'(i * 7); mem2[i] = 8'h00;
    end
    tick(2);
    check("rst_cs_b", sram_cs_b, 1);
    check("rst_oe_b", sram_oe_b, 1);
    check("rst_we_b", sram_we_b, 1);
    check("rst_dout_en", sram_dout_en, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready", req_ready, 0);
    rst = 0;
    tick();
    check("ready_after_rst", req_ready, 1);
    // write 0xA5 to 0x155 with per-cycle strobe checks
    issue(1, 11'h155, 8'hA5);
    req_valid = 0;
    check("wsetup_cs", sram_cs_b, 0);
    check("wsetup_we", sram_we_b, 1);
    check("wsetup_den", sram_dout_en, 1);
    check("wsetup_addr", sram_addr, 11'h155);
    check("wsetup_dout", sram_dout, 8'hA5);
    check("wsetup_ready", req_ready, 0);
    tick();
    check("wpulse_we", sram_we_b, 0);
    check("wpulse_addr", sram_addr, 11'h155);
    check("wpulse_dout", sram_dout, 8'hA5);
    tick();
    check("whold_we", sram_we_b, 1);
    check("whold_cs", sram_cs_b, 0);
    check("whold_den", sram_dout_en, 1);
    check("whold_dout", sram_dout, 8'hA5);
    tick();
    check("widle_cs", sram_cs_b, 1);
    check("widle_den", sram_dout_en, 0);
    check("widle_ready", req_ready, 1);
    // read back 0x155
    issue(0, 11'h155, 0);
    req_valid = 0;
    check("racc_oe", sram_oe_b, 0);
    check("racc_cs", sram_cs_b, 0);
    check("racc_rsp", rsp_valid, 0);
    tick();
    check("rsp_pulse", rsp_valid, 1);
    check("rsp_data", rsp_rdata, 8'hA5);
    check("rturn_cs", sram_cs_b, 1);
    check("rturn_oe", sram_oe_b, 1);
    tick();
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after_rd", req_ready, 1);
    // read then write to 0x000: turnaround cycle before the bus is driven
    issue(0, 11'h155, 0);
    req_wr = 1; req_addr = 11'h000; req_wdata = 8'h5C; exp_mem[0] = 8'h5C;
    tick();
    check("turn_cs", sram_cs_b, 1);
    check("turn_oe", sram_oe_b, 1);
    check("turn_den", sram_dout_en, 0);
    check("turn_ready", req_ready, 0);
    tick();
    check("turn_idle_ready", req_ready, 1);
    check("turn_idle_den", sram_dout_en, 0);
    tick();
    req_valid = 0;
    check("wr_after_rd_den", sram_dout_en, 1);
    tick(3);
    issue(0, 11'h000, 0);
    req_valid = 0;
    tick(3);
    // reset during W_PULSE
    issue(1, 11'h020, 8'h99);
    req_valid = 0;
    tick();
    check("midrst_pulse_we", sram_we_b, 0);
    rst = 1;
    tick();
    check("midrst_we", sram_we_b, 1);
    check("midrst_cs", sram_cs_b, 1);
    check("midrst_den", sram_dout_en, 0);
    check("midrst_ready", req_ready, 0);
    rst = 0;
    tick();
    check("midrst_ready_after", req_ready, 1);
    // back-to-back reads with req_valid held
    rsp_t.delete();
    for (int i = 0; i < 4; i++) issue(0, 11'h010 + 11'(i), 0);
    req_valid = 0;
    for (n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    check("b2b_drain", exp_q.size(), 0);
    check("b2b_count", rsp_t.size(), 4);
    for (int i = 1; i < 4; i++) check("b2b_gap", rsp_t[i] - rsp_t[i-1], GAP);
    tick(3);
    // req_valid held through a write
    r0 = hs; w0 = we_low;
    req_valid = 1; req_wr = 1; req_addr = 11'h030; req_wdata = 8'h77; exp_mem[11'h030] = 8'h77;
    wait_ready();
    tick(4);
    req_valid = 0;
    tick();
    check("held_handshakes", hs - r0, 1);
    check("held_we_cycles", we_low - w0, 1);
    issue(0, 11'h030, 0);
    req_valid = 0;
    tick(3);
    // WR_PULSE_CYC=3, RD_WAIT_CYC=2 instance
    v2 = 1; wr2 = 1; a2 = 11'h7FF; d2 = 8'h3C;
    check("p2_ready", rdy2, 1);
    tick();
    v2 = 0;
    r0 = rdy2_low; w0 = we2_low;
    for (n = 0; n < 20 && !rdy2; n++) tick();
    check("p2_ready_low", rdy2_low - r0, 5);
    check("p2_we_low", we2_low - w0, 3);
    v2 = 1; wr2 = 0; q2.push_back(8'h3C);
    o0 = oe2_low;
    tick();
    v2 = 0;
    tick(5);
    check("p2_oe_low", oe2_low - o0, 2);
    check("p2_rsp_count", rsp2_n, 1);
    check("scoreboard_empty", exp_q.size() + q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
- Synchronous front-end that converts single-clock read/write requests into asynchronous SRAM strobe sequences.
- Drives the 2048x8 asynchronous SRAM: address, active-low CS_b/OE_b/WE_b, and the tri-stated data bus.
- Guarantees the SRAM's address-setup, write-pulse, data-setup/hold and output-turnaround timing using whole clock cycles.
- Sits between the system request bus and the SRAM pins.

Parameters:
- ADDR_W, 11, SRAM address width.
- DATA_W, 8, SRAM word width.
- RD_WAIT_CYC, 1, cycles OE_b/CS_b are held low before read data is sampled; must be >=1 and RD_WAIT_CYC*Tclk >= 8 ns (t_AA).
- WR_PULSE_CYC, 1, cycles WE_b is held low; must be >=1 and WR_PULSE_CYC*Tclk >= 5 ns (t_WP).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata valid (reads only).
- rsp_rdata  out  DATA_W  read data.
- sram_addr  out  ADDR_W  SRAM address.
- sram_cs_b  out  1  chip select, active-low.
- sram_oe_b  out  1  output enable, active-low.
- sram_we_b  out  1  write enable, active-low.
- sram_dout  out  DATA_W  data to SRAM.
- sram_dout_en  out  1  tri-state enable for sram_dout; the top level resolves it onto the inout bus.
- sram_din  in  DATA_W  data from SRAM bus.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Registered outputs: every output is registered, so no strobe glitches.
- Reset values: sram_cs_b=1, sram_oe_b=1, sram_we_b=1, sram_dout_en=0, sram_addr=0, sram_dout=0, rsp_valid=0, rsp_rdata=0, req_ready=0 while rst=1, state=IDLE.
- Handshake: a transfer occurs on an edge with req_valid && req_ready. req_ready=1 only in IDLE. Request fields are captured at the handshake edge and held unchanged until the operation ends. No response backpressure.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_TURN.
- IDLE: all strobes high, dout_en=0. On accept: write -> W_SETUP, read -> R_ACCESS.
- W_SETUP (1 cycle): addr and dout valid, dout_en=1, CS_b=0, WE_b=1, OE_b=1. Satisfies t_AS=0.
- W_PULSE (WR_PULSE_CYC cycles): WE_b=0; addr and data stable. Gives t_DW >= one full cycle.
- W_HOLD (1 cycle): WE_b=1, CS_b=0, data still driven. Satisfies t_DH/t_WR=0. Next state IDLE, with dout_en=0 and CS_b=1.
- Write occupancy: WR_PULSE_CYC+2 cycles, accept to req_ready.
- R_ACCESS (RD_WAIT_CYC cycles): CS_b=0, OE_b=0, WE_b=1, dout_en=0.
  - On the edge ending the last cycle: rsp_rdata<=sram_din, rsp_valid<=1 for exactly one cycle.
  - Read latency: RD_WAIT_CYC+1 edges from accept to rsp_valid high.
- R_TURN (1 cycle): CS_b=1, OE_b=1. Covers t_OHZ/t_CHZ before any write drives the bus. Next state IDLE.
- Cycle counter: one down-counter, loaded with (WR_PULSE_CYC-1) or (RD_WAIT_CYC-1) on state entry; transition when it reads 0.
- Invariants (must hold every cycle):
  - sram_dout_en=1 implies sram_oe_b=1.
  - sram_we_b=0 implies sram_cs_b=0.
- Reset mid-operation: on the next edge all strobes return high and dout_en drops. The in-flight write is undefined in SRAM. The in-flight read produces no rsp_valid.
- req_valid while busy: ignored, not queued.

Optional Feature:
- Macro: SRAM_ASYNC_CTRL_B2B_RD_EN.
- When defined:
  - In the last R_ACCESS cycle, if req_valid && !req_wr, the controller accepts the request: req_ready=1 combinationally in that cycle only.
  - It re-enters R_ACCESS with the new address; CS_b/OE_b stay low and R_TURN is skipped.
  - Sustained read throughput is one read per RD_WAIT_CYC cycles.
  - A write request in that cycle is not accepted and goes through R_TURN as normal.
- When undefined: every read passes through R_TURN and IDLE; throughput is one read per RD_WAIT_CYC+2 cycles.

Decomposition:
- Package sram_async_ctrl_pkg holds:
  - state enumeration;
  - ADDR_W/DATA_W defaults;
  - default timing constants in ns (T_AA=8, T_WP=5, T_DW=3.5, T_OHZ=3.5) for elaboration-time parameter checks.
- Sub-module sram_async_ctrl_cnt: loadable down-counter with zero flag, width $clog2(max(RD_WAIT_CYC, WR_PULSE_CYC))+1.

Test Plan:
- Write 0xA5 to addr 0x155, then read 0x155 (defaults) -> WE_b low exactly 1 cycle with sram_dout=0xA5 and addr=0x155 stable from W_SETUP through W_HOLD; rsp_valid pulses 2 edges after read accept with rsp_rdata=0xA5.
- WR_PULSE_CYC=3, RD_WAIT_CYC=2: write 0x3C to 0x7FF, read back -> WE_b low 3 cycles, req_ready low 5 cycles; OE_b low 2 cycles; rsp_rdata=0x3C.
- Read immediately followed by a write to 0x000 -> one R_TURN cycle with CS_b=OE_b=1 before dout_en rises; the dout_en/OE_b invariant is never violated.
- rst asserted during W_PULSE -> next edge: WE_b=CS_b=1, dout_en=0, req_ready=0; req_ready=1 the cycle after rst falls.
- Four back-to-back reads of 0x010..0x013 holding req_valid -> with SRAM_ASYNC_CTRL_B2B_RD_EN, rsp_valid every RD_WAIT_CYC cycles and OE_b continuously low; without it, every RD_WAIT_CYC+2 cycles.
- req_valid held high during a write -> only one handshake is recorded; no extra SRAM access occurs.
